// File: rtl/ascii_pkg.sv
// Shared constants and FSM encoding for the ASCII number parser.
package ascii_pkg;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_F_UP = 8'h46;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_F_LO = 8'h66;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational character classifier: maps an ASCII byte to a digit value,
// with hex letters accepted only while hex_en is high.
module ascii_digit_decode
  import ascii_pkg::*;
(
  input  logic [7:0] char_in,
  input  logic       hex_en,
  output logic [3:0] digit,
  output logic       is_digit,
  output logic       is_term
);

  always_comb begin
    digit    = 4'hF;
    is_digit = 1'b0;
    is_term  = (char_in == ASCII_CR) || (char_in == ASCII_LF);
    if (char_in >= ASCII_0 && char_in <= ASCII_9) begin
      digit    = 4'(char_in - ASCII_0);
      is_digit = 1'b1;
    end else if (hex_en && char_in >= ASCII_A_UP && char_in <= ASCII_F_UP) begin
      digit    = 4'(char_in - ASCII_A_UP + 8'd10);
      is_digit = 1'b1;
    end else if (hex_en && char_in >= ASCII_A_LO && char_in <= ASCII_F_LO) begin
      digit    = 4'(char_in - ASCII_A_LO + 8'd10);
      is_digit = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_num_parser.sv
// Accumulates ASCII digits into a binary value, emitted on CR/LF.
// Define ASCII_PARSER_HEX_EN to accept hexadecimal numbers when hex_mode=1.
module ascii_num_parser
  import ascii_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int OUT_W      = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            char_valid,
  input  logic [7:0]                      char_in,
  input  logic                            hex_mode,
  output logic [OUT_W-1:0]                value,
  output logic                            value_valid,
  output logic                            error,
  output logic                            busy,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               busy_q;

  logic [3:0]         digit;
  logic               isDigit;
  logic               isTerm;
  logic               hexSel;
  logic [OUT_W-1:0]   digitExt;
  logic [OUT_W-1:0]   accNext;

  ascii_digit_decode uDecode (
    .char_in  (char_in),
    .hex_en   (hexSel),
    .digit    (digit),
    .is_digit (isDigit),
    .is_term  (isTerm)
  );

  assign digitExt = {{(OUT_W-4){1'b0}}, digit};

`ifdef ASCII_PARSER_HEX_EN
  logic baseHex_q, baseHex_d;

  // The base is taken from hex_mode on the first digit and held for the rest of the number.
  assign hexSel  = (state_q == IDLE) ? hex_mode : baseHex_q;
  assign accNext = baseHex_q ? ((acc_q << 4) + digitExt)
                             : ((acc_q << 3) + (acc_q << 1) + digitExt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) baseHex_q <= 1'b0;
    else       baseHex_q <= baseHex_d;
  end
`else
  logic unused_hexMode;

  assign unused_hexMode = hex_mode;
  assign hexSel         = 1'b0;
  assign accNext        = (acc_q << 3) + (acc_q << 1) + digitExt;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    error_d = 1'b0;
`ifdef ASCII_PARSER_HEX_EN
    baseHex_d = baseHex_q;
`endif
    if (char_valid) begin
      case (state_q)
        IDLE: begin
          if (isDigit) begin
            acc_d   = digitExt;
            count_d = CNT_W'(1);
            state_d = ACCUM;
`ifdef ASCII_PARSER_HEX_EN
            baseHex_d = hex_mode;
`endif
          end else if (!isTerm) begin
            error_d = 1'b1;
            state_d = FLUSH;
          end
        end
        ACCUM: begin
          if (isDigit && count_q < CNT_W'(MAX_DIGITS)) begin
            acc_d   = accNext;
            count_d = count_q + CNT_W'(1);
          end else if (isTerm) begin
            value_d = acc_q;
            valid_d = 1'b1;
            acc_d   = '0;
            count_d = '0;
            state_d = IDLE;
          end else begin
            // Invalid character or one digit too many: abandon the number.
            error_d = 1'b1;
            acc_d   = '0;
            count_d = '0;
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          if (isTerm) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign error       = error_q;
  assign busy        = busy_q;
  assign digit_count = count_q;

endmodule
